uart_tx: RTL and testbench

- UART transmit serializer; the upstream stage that drives the serial `dataline` consumed by the UART receiver.
- Accepts a byte over a valid/ready handshake and emits one frame on `dataline`: start bit, data LSB first, optional parity, stop bit(s).
- Bit period is set at run time by the same 16-bit `baudrate` divisor the receiver uses, so the TX-to-RX loopback bench shares one configuration.

---
 rtl/uart_tx.sv | 137 +++++++++++++
 tb/tb_uart_tx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmit serializer: start bit, DATA_BITS data bits LSB first, optional parity, stop bit(s).
// Bit period is latched from `baudrate` when a byte is accepted (0 is treated as 1).
module uart_tx #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          baudrate,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 dataline,
    output logic                 busy
);

    localparam int unsigned BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state_q;
    logic [15:0]          period_q;
    logic [15:0]          period_d;
    logic [15:0]          cnt_q;
    logic [15:0]          cnt_d;
    logic [BW-1:0]        bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 parity_q;
    logic                 parity_d;
    logic                 ready_q;
    logic                 dataline_q;
    logic                 busy_q;
    logic                 bit_end;

    always_comb begin
        period_d = (baudrate == 16'd0) ? 16'd1 : baudrate;
        parity_d = (^data) ^ (PARITY_ODD != 0);
        bit_end  = (cnt_q == period_q - 16'd1);
        cnt_d    = bit_end ? '0 : cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            period_q   <= '0;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            ready_q    <= 1'b0;
            dataline_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // ready_q gates acceptance, so the first edge after reset only raises ready
                    ready_q    <= 1'b1;
                    dataline_q <= 1'b1;
                    busy_q     <= 1'b0;
                    if (valid && ready_q) begin
                        state_q    <= START;
                        shift_q    <= data;
                        period_q   <= period_d;
                        parity_q   <= parity_d;
                        cnt_q      <= '0;
                        bit_q      <= '0;
                        dataline_q <= 1'b0;
                        busy_q     <= 1'b1;
                        ready_q    <= 1'b0;
                    end
                end
                START: begin
                    cnt_q <= cnt_d;
                    if (bit_end) begin
                        state_q    <= DATA;
                        dataline_q <= shift_q[0];
                    end
                end
                DATA: begin
                    cnt_q <= cnt_d;
                    if (bit_end) begin
                        if (bit_q == LAST_DATA) begin
                            bit_q <= '0;
                            if (PARITY_EN != 0) begin
                                state_q    <= PARITY;
                                dataline_q <= parity_q;
                            end else begin
                                state_q    <= STOP;
                                dataline_q <= 1'b1;
                            end
                        end else begin
                            bit_q      <= bit_q + 1'b1;
                            shift_q    <= shift_q >> 1;
                            dataline_q <= shift_q[1];
                        end
                    end
                end
                PARITY: begin
                    cnt_q <= cnt_d;
                    if (bit_end) begin
                        state_q    <= STOP;
                        dataline_q <= 1'b1;
                    end
                end
                STOP: begin
                    cnt_q <= cnt_d;
                    if (bit_end) begin
                        if (bit_q == LAST_STOP) begin
                            state_q <= IDLE;
                            bit_q   <= '0;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready    = ready_q;
    assign dataline = dataline_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: default framing plus even/odd parity instances sharing clock, reset and baudrate.
module tb_uart_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] baudrate;

    logic [7:0] data0, data_pe, data_po;
    logic       valid0, valid_pe, valid_po;
    logic       ready0, ready_pe, ready_po;
    logic       line0, line_pe, line_po;
    logic       busy0, busy_pe, busy_po;

    int nchk = 0;
    int nerr = 0;

    logic ln_s [0:255];
    logic bz_s [0:255];
    logic rd_s [0:255];

    always #5 clk = ~clk;

    uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .baudrate(baudrate), .data(data0), .valid(valid0),
        .ready(ready0), .dataline(line0), .busy(busy0)
    );

    uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_pe (
        .clk(clk), .rst(rst), .baudrate(baudrate), .data(data_pe), .valid(valid_pe),
        .ready(ready_pe), .dataline(line_pe), .busy(busy_pe)
    );

    uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_po (
        .clk(clk), .rst(rst), .baudrate(baudrate), .data(data_po), .valid(valid_po),
        .ready(ready_po), .dataline(line_po), .busy(busy_po)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Records outputs of instance `sel` after each of n edges, starting with the current one.
    task automatic capture(input int sel, input int base, input int n);
        for (int i = 0; i < n; i++) begin
            case (sel)
                1:       begin ln_s[base+i] = line_pe; bz_s[base+i] = busy_pe; rd_s[base+i] = ready_pe; end
                2:       begin ln_s[base+i] = line_po; bz_s[base+i] = busy_po; rd_s[base+i] = ready_po; end
                default: begin ln_s[base+i] = line0;   bz_s[base+i] = busy0;   rd_s[base+i] = ready0;   end
            endcase
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        baudrate = 16'd4;
        data0 = '0; data_pe = '0; data_po = '0;
        valid0 = 1'b0; valid_pe = 1'b0; valid_po = 1'b0;
        #12;
        nchk++; if (line0 !== 1'b1) begin nerr++; $display("FAIL reset_line: got %b want 1", line0); end
        nchk++; if (busy0 !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", busy0); end
        nchk++; if (ready0 !== 1'b0) begin nerr++; $display("FAIL reset_ready: got %b want 0", ready0); end
        tick(); tick();
        nchk++; if (ready0 !== 1'b0) begin nerr++; $display("FAIL reset_ready_held: got %b want 0", ready0); end
        rst = 1'b1;
        tick();
        nchk++; if (ready0 !== 1'b1) begin nerr++; $display("FAIL release_ready: got %b want 1", ready0); end
        nchk++; if (ready_pe !== 1'b1) begin nerr++; $display("FAIL release_ready_pe: got %b want 1", ready_pe); end
        nchk++; if (ready_po !== 1'b1) begin nerr++; $display("FAIL release_ready_po: got %b want 1", ready_po); end
    endtask

    task automatic test_basic();
        logic [15:0] f;
        f = {6'b0, 1'b1, 8'hA5, 1'b0};
        nchk++; if (ready0 !== 1'b1) begin nerr++; $display("FAIL basic_ready_pre: got %b want 1", ready0); end
        data0 = 8'hA5; baudrate = 16'd4; valid0 = 1'b1;
        tick();
        valid0 = 1'b0;
        capture(0, 0, 41);
        for (int i = 0; i < 40; i++) begin
            nchk++; if (ln_s[i] !== f[i/4]) begin nerr++; $display("FAIL basic_line[%0d]: got %b want %b", i, ln_s[i], f[i/4]); end
            nchk++; if (bz_s[i] !== 1'b1) begin nerr++; $display("FAIL basic_busy[%0d]: got %b want 1", i, bz_s[i]); end
            nchk++; if (rd_s[i] !== 1'b0) begin nerr++; $display("FAIL basic_ready[%0d]: got %b want 0", i, rd_s[i]); end
        end
        nchk++; if (ln_s[40] !== 1'b1) begin nerr++; $display("FAIL basic_end_line: got %b want 1", ln_s[40]); end
        nchk++; if (bz_s[40] !== 1'b0) begin nerr++; $display("FAIL basic_end_busy: got %b want 0", bz_s[40]); end
        nchk++; if (rd_s[40] !== 1'b1) begin nerr++; $display("FAIL basic_end_ready: got %b want 1", rd_s[40]); end
    endtask

    task automatic test_parity();
        logic [15:0] f;
        baudrate = 16'd2;
        for (int s = 1; s <= 2; s++) begin
            // 0x07 has three ones: even parity bit 1, odd parity bit 0
            f = (s == 1) ? {5'b0, 1'b1, 1'b1, 8'h07, 1'b0} : {5'b0, 1'b1, 1'b0, 8'h07, 1'b0};
            if (s == 1) begin data_pe = 8'h07; valid_pe = 1'b1; end
            else        begin data_po = 8'h07; valid_po = 1'b1; end
            tick();
            valid_pe = 1'b0; valid_po = 1'b0;
            capture(s, 0, 23);
            for (int i = 0; i < 22; i++) begin
                nchk++; if (ln_s[i] !== f[i/2]) begin nerr++; $display("FAIL parity%0d_line[%0d]: got %b want %b", s, i, ln_s[i], f[i/2]); end
                nchk++; if (bz_s[i] !== 1'b1) begin nerr++; $display("FAIL parity%0d_busy[%0d]: got %b want 1", s, i, bz_s[i]); end
            end
            nchk++; if (bz_s[22] !== 1'b0) begin nerr++; $display("FAIL parity%0d_end_busy: got %b want 0", s, bz_s[22]); end
            nchk++; if (rd_s[22] !== 1'b1) begin nerr++; $display("FAIL parity%0d_end_ready: got %b want 1", s, rd_s[22]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] f1, f2;
        f1 = {6'b0, 1'b1, 8'h55, 1'b0};
        f2 = {6'b0, 1'b1, 8'hAA, 1'b0};
        baudrate = 16'd3; data0 = 8'h55; valid0 = 1'b1;
        tick();
        data0 = 8'hAA;
        capture(0, 0, 31);
        valid0 = 1'b0;
        capture(0, 31, 40);
        for (int i = 0; i < 30; i++) begin
            nchk++; if (ln_s[i] !== f1[i/3]) begin nerr++; $display("FAIL b2b_first[%0d]: got %b want %b", i, ln_s[i], f1[i/3]); end
        end
        nchk++; if (ln_s[30] !== 1'b1) begin nerr++; $display("FAIL b2b_gap_line: got %b want 1", ln_s[30]); end
        nchk++; if (rd_s[30] !== 1'b1) begin nerr++; $display("FAIL b2b_gap_ready: got %b want 1", rd_s[30]); end
        nchk++; if (rd_s[31] !== 1'b0) begin nerr++; $display("FAIL b2b_second_ready: got %b want 0", rd_s[31]); end
        for (int i = 31; i < 61; i++) begin
            nchk++; if (ln_s[i] !== f2[(i-31)/3]) begin nerr++; $display("FAIL b2b_second[%0d]: got %b want %b", i, ln_s[i], f2[(i-31)/3]); end
            nchk++; if (bz_s[i] !== 1'b1) begin nerr++; $display("FAIL b2b_second_busy[%0d]: got %b want 1", i, bz_s[i]); end
        end
        for (int i = 61; i < 71; i++) begin
            nchk++; if (ln_s[i] !== 1'b1) begin nerr++; $display("FAIL b2b_idle_line[%0d]: got %b want 1", i, ln_s[i]); end
            nchk++; if (bz_s[i] !== 1'b0) begin nerr++; $display("FAIL b2b_idle_busy[%0d]: got %b want 0", i, bz_s[i]); end
        end
    endtask

    task automatic test_baud_change();
        logic [15:0] f1, f2;
        f1 = {6'b0, 1'b1, 8'h3C, 1'b0};
        f2 = {6'b0, 1'b1, 8'hC3, 1'b0};
        baudrate = 16'd8; data0 = 8'h3C; valid0 = 1'b1;
        tick();
        valid0 = 1'b0;
        capture(0, 0, 20);
        baudrate = 16'd2;
        capture(0, 20, 61);
        for (int i = 0; i < 80; i++) begin
            nchk++; if (ln_s[i] !== f1[i/8]) begin nerr++; $display("FAIL baud8_line[%0d]: got %b want %b", i, ln_s[i], f1[i/8]); end
        end
        nchk++; if (rd_s[80] !== 1'b1) begin nerr++; $display("FAIL baud8_end_ready: got %b want 1", rd_s[80]); end
        data0 = 8'hC3; valid0 = 1'b1;
        tick();
        valid0 = 1'b0;
        capture(0, 0, 21);
        for (int i = 0; i < 20; i++) begin
            nchk++; if (ln_s[i] !== f2[i/2]) begin nerr++; $display("FAIL baud2_line[%0d]: got %b want %b", i, ln_s[i], f2[i/2]); end
        end
        nchk++; if (rd_s[20] !== 1'b1) begin nerr++; $display("FAIL baud2_end_ready: got %b want 1", rd_s[20]); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] f;
        f = {6'b0, 1'b1, 8'h12, 1'b0};
        baudrate = 16'd4; data0 = 8'hF0; valid0 = 1'b1;
        tick();
        valid0 = 1'b0;
        capture(0, 0, 17);
        nchk++; if (ln_s[16] !== 1'b0) begin nerr++; $display("FAIL mid_bit3_line: got %b want 0", ln_s[16]); end
        #2;
        rst = 1'b0;
        #1;
        nchk++; if (line0 !== 1'b1) begin nerr++; $display("FAIL mid_rst_line: got %b want 1", line0); end
        nchk++; if (busy0 !== 1'b0) begin nerr++; $display("FAIL mid_rst_busy: got %b want 0", busy0); end
        nchk++; if (ready0 !== 1'b0) begin nerr++; $display("FAIL mid_rst_ready: got %b want 0", ready0); end
        tick(); tick();
        nchk++; if (line0 !== 1'b1) begin nerr++; $display("FAIL mid_rst_hold_line: got %b want 1", line0); end
        rst = 1'b1;
        tick();
        nchk++; if (ready0 !== 1'b1) begin nerr++; $display("FAIL mid_release_ready: got %b want 1", ready0); end
        data0 = 8'h12; valid0 = 1'b1;
        tick();
        valid0 = 1'b0;
        capture(0, 0, 41);
        for (int i = 0; i < 40; i++) begin
            nchk++; if (ln_s[i] !== f[i/4]) begin nerr++; $display("FAIL mid_new_line[%0d]: got %b want %b", i, ln_s[i], f[i/4]); end
        end
        nchk++; if (rd_s[40] !== 1'b1) begin nerr++; $display("FAIL mid_new_end_ready: got %b want 1", rd_s[40]); end
    endtask

    task automatic test_edge_periods();
        logic [15:0] f;
        f = {6'b0, 1'b1, 8'hFF, 1'b0};
        for (int b = 0; b <= 1; b++) begin
            baudrate = 16'(b); data0 = 8'hFF; valid0 = 1'b1;
            tick();
            valid0 = 1'b0;
            capture(0, 0, 3);
            data0 = 8'h00; valid0 = 1'b1;
            capture(0, 3, 2);
            valid0 = 1'b0;
            capture(0, 5, 15);
            for (int i = 0; i < 10; i++) begin
                nchk++; if (ln_s[i] !== f[i]) begin nerr++; $display("FAIL edge%0d_line[%0d]: got %b want %b", b, i, ln_s[i], f[i]); end
                nchk++; if (bz_s[i] !== 1'b1) begin nerr++; $display("FAIL edge%0d_busy[%0d]: got %b want 1", b, i, bz_s[i]); end
            end
            nchk++; if (rd_s[10] !== 1'b1) begin nerr++; $display("FAIL edge%0d_end_ready: got %b want 1", b, rd_s[10]); end
            for (int i = 10; i < 20; i++) begin
                nchk++; if (ln_s[i] !== 1'b1) begin nerr++; $display("FAIL edge%0d_idle_line[%0d]: got %b want 1", b, i, ln_s[i]); end
                nchk++; if (bz_s[i] !== 1'b0) begin nerr++; $display("FAIL edge%0d_idle_busy[%0d]: got %b want 0", b, i, bz_s[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_baud_change();
        test_reset_mid();
        test_edge_periods();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
